uart_tx_frame_ctrl: RTL and testbench

Transmit-side frame sequencer for the full-duplex UART core. It accepts one byte per handshake and generates its own bit timing from the system clock. It drives the serial line as start bit, 8 data bits LSB first, an optional parity bit and 1 or 2 stop bits. Parity is computed on the latched byte with the core-wide convention: parity_type 1 = ODD, 0 = EVEN.

---
 rtl/uart_tx_frame_ctrl.sv | 152 +++++++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame sequencer: start bit, 8 data bits LSB first,
// optional parity bit and one or two stop bits. Bit timing is derived
// from the system clock with a per-bit cycle counter. All outputs are
// registered.
module uart_tx_frame_ctrl #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       stop_bits,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;      // data bit index, or stop-bit index in STOP
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;      // parity bit computed at acceptance
    logic             par_en_q, par_en_d;
    logic             stop2_q, stop2_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

    // State and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
            stop2_q  <= stop2_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and next-output logic. tx_d is the level the line takes
    // for the bit that begins at the coming edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        par_en_d = par_en_q;
        stop2_d  = stop2_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (state_q == IDLE) begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (tx_start) begin
                shift_d  = tx_data;
                par_d    = parity_type ? ~^tx_data : ^tx_data;
                par_en_d = parity_en;
                stop2_d  = stop_bits;
                state_d  = START;
                cnt_d    = '0;
                bit_d    = '0;
                tx_d     = 1'b0;
                busy_d   = 1'b1;
            end
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
            unique case (state_q)
                START: begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
                DATA: begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
                STOP: begin
                    tx_d = 1'b1;
                    if (stop2_q && (bit_q == 3'd0)) begin
                        bit_d = 3'd1;
                    end else begin
                        state_d = IDLE;
                        bit_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench for uart_tx_frame_ctrl: stimulus pushes the expected
// frame built from the framing rules; a monitor captures each frame from
// the serial line and compares it.
module tb_uart_tx_frame_ctrl;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;
    logic       stop_bits = 1'b0;
    logic       tx, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        bit          b2b;
        logic [7:0]  data;
    } exp_t;

    exp_t exp_q[$];

    uart_tx_frame_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
        .parity_en(parity_en), .parity_type(parity_type), .stop_bits(stop_bits),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference frame: list of line levels, one per bit period.
    function automatic exp_t model(input logic [7:0] d, input bit pe, input bit pt,
                                   input bit sb, input bit b2b);
        exp_t e;
        int   ones = 0;
        int   n = 0;
        e.bits = '0;
        e.b2b = b2b;
        e.data = d;
        e.bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin
            e.bits[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (pe) begin
            // ODD: total count of ones incl. parity is odd; EVEN: even.
            e.bits[n] = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
            n++;
        end
        e.bits[n] = 1'b1; n++;
        if (sb) begin
            e.bits[n] = 1'b1; n++;
        end
        e.nbits = n;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    bit   in_frame = 0;
    int   cyc = 0;
    int   bit_err = 0;
    int   idle_cnt = 0;
    exp_t cur;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (in_frame) begin
                    in_frame = 0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    $display("frame data=%02h aborted by reset", cur.data);
                end
                idle_cnt = 0;
            end else if (!in_frame && busy) begin
                chk("frame_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    if (cur.b2b) chk("b2b_idle_gap", idle_cnt, 1);
                    in_frame = 1;
                    cyc = 0;
                    bit_err = 0;
                    if (tx !== cur.bits[0]) bit_err++;
                    cyc = 1;
                end
                chk("done_low_in_frame", int'(done), 0);
            end else if (in_frame && busy) begin
                if (cyc / CPB < cur.nbits) begin
                    if (tx !== cur.bits[cyc / CPB]) bit_err++;
                end else begin
                    bit_err++;
                end
                cyc++;
                if (done) chk("done_low_in_frame", int'(done), 0);
            end else if (in_frame && !busy) begin
                in_frame = 0;
                chk("frame_bits", bit_err, 0);
                chk("frame_len", cyc, cur.nbits * CPB);
                chk("done_at_end", int'(done), 1);
                chk("tx_idle_at_end", int'(tx), 1);
                $display("frame data=%02h nbits=%0d cycles=%0d bit_errors=%0d",
                         cur.data, cur.nbits, cyc, bit_err);
                idle_cnt = 1;
            end else begin
                idle_cnt++;
                if (done !== 1'b0 || tx !== 1'b1) begin
                    chk("idle_done", int'(done), 0);
                    chk("idle_tx", int'(tx), 1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int k = 0;
        while (busy && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("wait_idle_timeout", int'(busy), 0);
    endtask

    task automatic send(input logic [7:0] d, input bit pe, input bit pt, input bit sb);
        @(posedge clk); #1;
        tx_data = d; parity_en = pe; parity_type = pt; stop_bits = sb;
        tx_start = 1'b1;
        exp_q.push_back(model(d, pe, pt, sb, 1'b0));
        @(posedge clk); #1;
        tx_start = 1'b0;
        chk("accept_busy", int'(busy), 1);
        wait_idle();
    endtask

    initial begin
        int idle_bad;
        int k;
        // reset state
        #12;
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // idle for 100 cycles
        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad++;
        end
        chk("idle_100", idle_bad, 0);

        // directed frames
        send(8'h55, 1, 0, 0);
        send(8'h07, 1, 1, 0);
        send(8'h07, 1, 0, 0);
        send(8'h00, 1, 1, 0);
        send(8'hA3, 0, 0, 1);

        // mid-frame tx_start pulse with changed inputs is ignored
        @(posedge clk); #1;
        tx_data = 8'h3C; parity_en = 1; parity_type = 1; stop_bits = 1;
        tx_start = 1'b1;
        exp_q.push_back(model(8'h3C, 1, 1, 1, 1'b0));
        @(posedge clk); #1;
        tx_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        tx_data = 8'hFF; parity_en = 0; parity_type = 0; stop_bits = 0;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk);

        // held tx_start: back-to-back frames with one idle cycle
        #1;
        tx_data = 8'h96; parity_en = 1; parity_type = 0; stop_bits = 0;
        tx_start = 1'b1;
        exp_q.push_back(model(8'h96, 1, 0, 0, 1'b0));
        exp_q.push_back(model(8'hFF, 0, 0, 1, 1'b1));
        @(posedge clk); #1;
        tx_data = 8'hFF; parity_en = 0; stop_bits = 1;
        k = 0;
        while (!done && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("b2b_done_seen", int'(done), 1);
        @(posedge clk); #1;
        tx_start = 1'b0;
        chk("b2b_accept", int'(busy), 1);
        wait_idle();

        // reset during DATA bit 3
        @(posedge clk); #1;
        tx_data = 8'hC5; parity_en = 1; parity_type = 1; stop_bits = 0;
        tx_start = 1'b1;
        exp_q.push_back(model(8'hC5, 1, 1, 0, 1'b0));
        @(posedge clk); #1;
        tx_start = 1'b0;
        repeat (CPB * 4 + 1) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_tx", int'(tx), 1);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h5A, 1, 0, 1);

        // randomized frames
        for (int i = 0; i < 20; i++) begin
            send(8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        repeat (10) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
